// File: rtl/count_strobe_conditioner_if.sv
// ============================================================================
// count_strobe_conditioner_if : raw request lines in, counter controls out
// Rev 1.0
// ============================================================================
`default_nettype none

interface count_strobe_conditioner_if;
  logic raw_up;
  logic raw_down;
  logic enable;
  logic increment;
  logic busy;

  modport master (
    output raw_up,
    output raw_down,
    input  enable,
    input  increment,
    input  busy
  );

  modport slave (
    input  raw_up,
    input  raw_down,
    output enable,
    output increment,
    output busy
  );
endinterface

`default_nettype wire

// File: rtl/count_strobe_conditioner.sv
// ============================================================================
// count_strobe_conditioner : sync + debounce up/down requests into strobes
// Rev 1.0
// ============================================================================
`default_nettype none

module count_strobe_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  count_strobe_conditioner_if.slave   bus
);

  localparam int T_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam logic [TW-1:0] DEB_T = TW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] REP_T = TW'(REPEAT_CYCLES);
  localparam logic [TW-1:0] SAT_T = {TW{1'b1}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   dir_q, dir_d;
  logic                   en_q, en_d;
  logic [SYNC_STAGES-1:0] up_sync_q;
  logic [SYNC_STAGES-1:0] dn_sync_q;

  logic          up;
  logic          dn;
  logic          sel;
  logic [TW-1:0] timer_inc;

  assign up        = up_sync_q[SYNC_STAGES-1];
  assign dn        = dn_sync_q[SYNC_STAGES-1];
  // Only the line latched at press time matters once we leave IDLE.
  assign sel       = dir_q ? up : dn;
  assign timer_inc = (timer_q == SAT_T) ? timer_q : timer_q + TW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_sync_q <= '0;
      dn_sync_q <= '0;
      state_q   <= IDLE;
      timer_q   <= '0;
      dir_q     <= 1'b1;
      en_q      <= 1'b0;
    end else begin
      up_sync_q <= {up_sync_q[SYNC_STAGES-2:0], bus.raw_up};
      dn_sync_q <= {dn_sync_q[SYNC_STAGES-2:0], bus.raw_down};
      state_q   <= state_d;
      timer_q   <= timer_d;
      dir_q     <= dir_d;
      en_q      <= en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    en_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (up ^ dn) begin
          dir_d   = up;
          timer_d = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (sel) begin
          timer_d = timer_inc;
          if (timer_inc == DEB_T) begin
            en_d    = 1'b1;
            timer_d = '0;
            state_d = HELD;
          end
        end else begin
          timer_d = '0;
          state_d = IDLE;
        end
      end
      HELD: begin
        if (sel) begin
          // Saturating timer never returns to zero, so the guard keeps REP_T=0 silent.
          if (REPEAT_CYCLES > 0) begin
            timer_d = timer_inc;
            if (timer_inc == REP_T) begin
              en_d    = 1'b1;
              timer_d = '0;
            end
          end
        end else begin
          timer_d = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!sel) begin
          timer_d = timer_inc;
          if (timer_inc == DEB_T) begin
            timer_d = '0;
            state_d = IDLE;
          end
        end else begin
          timer_d = '0;
          state_d = HELD;
        end
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.enable    = en_q;
  assign bus.increment = dir_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_count_strobe_conditioner.sv
// ============================================================================
// tb_count_strobe_conditioner : directed checks on two conditioner instances
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_count_strobe_conditioner;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #1 clk = ~clk;

  count_strobe_conditioner_if ifa ();
  count_strobe_conditioner_if ifb ();

  count_strobe_conditioner #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .REPEAT_CYCLES(0)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
  );

  count_strobe_conditioner #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .REPEAT_CYCLES(10)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Per-window observations, edge numbers relative to the last clr().
  int edg, pa, fa, ia, ba, za, busy_ever_a;
  int pb, fb, lb, gapbad_b;
  int cnt_b = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    edg = 0; pa = 0; fa = -1; ia = -1; ba = -1; za = -1; busy_ever_a = 0;
    pb = 0; fb = -1; lb = -1; gapbad_b = 0;
  endtask

  // Advance n rising edges; observe at the following falling edge.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      edg++;
      if (ifa.enable === 1'b1) begin
        pa++;
        if (fa < 0) begin fa = edg; ia = int'(ifa.increment); end
      end
      if (ifa.busy === 1'b1) begin
        busy_ever_a = 1;
        if (ba < 0) ba = edg;
      end else if (za < 0) begin
        za = edg;
      end
      if (ifb.enable === 1'b1) begin
        pb++;
        if (fb < 0) fb = edg;
        else if (edg - lb != 10) gapbad_b++;
        lb = edg;
        cnt_b += (ifb.increment === 1'b1) ? 1 : -1;
      end
    end
  endtask

  initial begin
    ifa.raw_up = 1'b0; ifa.raw_down = 1'b0;
    ifb.raw_up = 1'b0; ifb.raw_down = 1'b0;
    clr();

    // 1: reset held for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_enable",    int'(ifa.enable),    0);
      chk("rst_increment", int'(ifa.increment), 1);
      chk("rst_busy",      int'(ifa.busy),      0);
    end
    rst_n = 1'b1;
    clr(); cyc(5);
    chk("post_rst_busy", int'(ifa.busy), 0);
    chk("post_rst_pulses", pa, 0);

    // 2: clean up press, then release
    ifa.raw_up = 1'b1;
    clr(); cyc(100);
    chk("press_pulses",   pa, 1);
    chk("press_latency",  fa, 19);
    chk("press_incr",     ia, 1);
    chk("press_busy_on",  ba, 3);
    chk("press_held_busy", int'(ifa.busy), 1);
    ifa.raw_up = 1'b0;
    clr(); cyc(40);
    chk("release_pulses", pa, 0);
    chk("release_idle_edge", za, 19);

    // 3: bouncing down line, then stable
    clr();
    for (int t = 0; t < 20; t++) begin
      ifa.raw_down = ~ifa.raw_down;
      cyc(3);
    end
    chk("bounce_pulses", pa, 0);
    ifa.raw_down = 1'b1;
    clr(); cyc(40);
    chk("down_pulses",  pa, 1);
    chk("down_latency", fa, 19);
    chk("down_incr",    ia, 0);
    ifa.raw_down = 1'b0;
    clr(); cyc(30);
    chk("down_idle",      int'(ifa.busy),      0);
    chk("down_incr_hold", int'(ifa.increment), 0);

    // 4: auto-repeat on the REPEAT_CYCLES=10 instance
    ifb.raw_up = 1'b1;
    clr(); cyc(200);
    ifb.raw_up = 1'b0;
    cyc(30);
    chk("rep_pulses", pb, 19);
    chk("rep_first",  fb, 19);
    chk("rep_last",   lb, 199);
    chk("rep_gaps",   gapbad_b, 0);
    chk("rep_count",  cnt_b, 19);
    chk("rep_idle",   int'(ifb.busy), 0);

    // 5: simultaneous up/down, then down while up is held
    ifa.raw_up = 1'b1; ifa.raw_down = 1'b1;
    clr(); cyc(40);
    chk("conflict_pulses", pa, 0);
    chk("conflict_busy",   busy_ever_a, 0);
    ifa.raw_up = 1'b0; ifa.raw_down = 1'b0;
    cyc(5);
    ifa.raw_up = 1'b1;
    clr(); cyc(25);
    chk("c_up_pulses",  pa, 1);
    chk("c_up_incr",    ia, 1);
    ifa.raw_down = 1'b1;
    clr(); cyc(40);
    chk("held_down_pulses", pa, 0);
    chk("held_dir",  int'(ifa.increment), 1);
    chk("held_busy", int'(ifa.busy), 1);
    // Releasing up with down still held: full release, then a fresh down press.
    ifa.raw_up = 1'b0;
    clr(); cyc(60);
    chk("swap_pulses",  pa, 1);
    chk("swap_latency", fa, 36);
    chk("swap_incr",    ia, 0);
    ifa.raw_down = 1'b0;
    cyc(30);

    // 6: reset during debounce with up still held
    ifa.raw_up = 1'b1;
    clr(); cyc(9);
    rst_n = 1'b0;
    cyc(4);
    chk("mid_rst_pulses", pa, 0);
    chk("mid_rst_busy",   int'(ifa.busy), 0);
    chk("mid_rst_incr",   int'(ifa.increment), 1);
    rst_n = 1'b1;
    clr(); cyc(30);
    chk("after_rst_pulses",  pa, 1);
    chk("after_rst_latency", fa, 19);
    chk("after_rst_incr",    ia, 1);
    ifa.raw_up = 1'b0;
    cyc(30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
